// File: rtl/drum_sequencer_pkg.sv
// Shared types and constants for the drum step sequencer.
package drum_sequencer_pkg;

    // Transport state of the sequencer
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } seq_state_e;

    // Transport command after same-cycle priority has been resolved
    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_START = 2'd1,
        CMD_PAUSE = 2'd2,
        CMD_STOP  = 2'd3
    } seq_cmd_e;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_NUM_STEPS  = 16;
    localparam int DEF_PER_W      = 24;

    // Shortest legal step period in clocks; smaller requests are raised to this
    localparam int MIN_PERIOD = 2;

    // stop beats pause, pause beats start
    function automatic seq_cmd_e decode_cmd(input logic start, input logic pause,
                                            input logic stop);
        seq_cmd_e cmd;
        cmd = CMD_NONE;
        if (stop) begin
            cmd = CMD_STOP;
        end else if (pause) begin
            cmd = CMD_PAUSE;
        end else if (start) begin
            cmd = CMD_START;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/drum_sequencer_if.sv
// Control/pattern/trigger bundle between the user-control logic and the sequencer.
interface drum_sequencer_if #(
    parameter int NUM_VOICES = 4,
    parameter int STEP_W     = 4,
    parameter int VOICE_W    = 2,
    parameter int PER_W      = 24
);
    logic                  start;
    logic                  pause;
    logic                  stop;
    logic [PER_W-1:0]      step_period;
    logic [NUM_VOICES-1:0] mute;
    logic                  pat_we;
    logic [VOICE_W-1:0]    pat_voice;
    logic [STEP_W-1:0]     pat_step;
    logic                  pat_val;
    logic [NUM_VOICES-1:0] go;
    logic [STEP_W-1:0]     step_idx;
    logic                  step_tick;
    logic                  running;

    modport master (
        output start, pause, stop, step_period, mute,
        output pat_we, pat_voice, pat_step, pat_val,
        input  go, step_idx, step_tick, running
    );

    modport slave (
        input  start, pause, stop, step_period, mute,
        input  pat_we, pat_voice, pat_step, pat_val,
        output go, step_idx, step_tick, running
    );
endinterface

// File: rtl/drum_sequencer_step_timer.sv
// Step-period timer: counts clocks within a step and flags the last clock of it.
module drum_sequencer_step_timer
    import drum_sequencer_pkg::*;
#(
    parameter int PER_W = DEF_PER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [PER_W-1:0] step_period,
    output logic             boundary
);

    logic [PER_W-1:0] tick_q, tick_d;
    logic [PER_W-1:0] per_q, per_d;

    // Periods below the minimum would make the step shorter than the fire pulse
    function automatic logic [PER_W-1:0] clamp_period(input logic [PER_W-1:0] p);
        return (p < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : p;
    endfunction

    // High during the last clock of the current step
    assign boundary = (tick_q == (per_q - PER_W'(1)));

    // Counter advance/wrap and period latch
    always_comb begin
        tick_d = tick_q;
        per_d  = per_q;
        if (clear) begin
            tick_d = '0;
        end else if (en) begin
            tick_d = boundary ? '0 : (tick_q + PER_W'(1));
        end
        if (load) begin
            per_d = clamp_period(step_period);
        end
    end

    // Timer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
            per_q  <= PER_W'(MIN_PERIOD);
        end else begin
            tick_q <= tick_d;
            per_q  <= per_d;
        end
    end

endmodule

// File: rtl/drum_sequencer.sv
// Drum step sequencer: transport FSM, pattern store and per-voice trigger pulses.
module drum_sequencer
    import drum_sequencer_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int NUM_STEPS  = DEF_NUM_STEPS,
    parameter int STEP_W     = 4,
    parameter int VOICE_W    = 2,
    parameter int PER_W      = DEF_PER_W
) (
    input logic              clk,
    input logic              reset,
    drum_sequencer_if.slave  bus
);

    seq_state_e            state_q, state_d;
    logic [STEP_W-1:0]     step_idx_q, step_idx_d;
    logic [NUM_VOICES-1:0] go_q, go_d;
    logic                  step_tick_q, step_tick_d;
    logic                  running_q, running_d;
    logic [NUM_VOICES-1:0] pattern_q [NUM_STEPS];
    logic [NUM_VOICES-1:0] pattern_d [NUM_STEPS];

    seq_cmd_e              cmd;
    logic                  fire;
    logic [STEP_W-1:0]     fire_step;
    logic                  tmr_en;
    logic                  tmr_clear;
    logic                  tmr_load;
    logic                  tmr_boundary;

    assign cmd = decode_cmd(bus.start, bus.pause, bus.stop);

    drum_sequencer_step_timer #(
        .PER_W (PER_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .en          (tmr_en),
        .clear       (tmr_clear),
        .load        (tmr_load),
        .step_period (bus.step_period),
        .boundary    (tmr_boundary)
    );

    // Transport FSM: next state, step index, timer control and fire request
    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        tmr_en     = 1'b0;
        tmr_clear  = 1'b0;
        tmr_load   = 1'b0;
        fire       = 1'b0;
        fire_step  = step_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd == CMD_START) begin
                    state_d    = ST_RUN;
                    step_idx_d = '0;
                    tmr_clear  = 1'b1;
                    tmr_load   = 1'b1;
                    fire       = 1'b1;
                    fire_step  = '0;
                end
            end
            ST_RUN: begin
                case (cmd)
                    CMD_STOP: begin
                        state_d    = ST_IDLE;
                        step_idx_d = '0;
                        tmr_clear  = 1'b1;
                    end
                    CMD_PAUSE: begin
                        state_d = ST_PAUSE;
                    end
                    default: begin
                        tmr_en = 1'b1;
                        if (tmr_boundary) begin
                            step_idx_d = step_idx_q + STEP_W'(1);
                            tmr_load   = 1'b1;
                            fire       = 1'b1;
                            fire_step  = step_idx_q + STEP_W'(1);
                        end
                    end
                endcase
            end
            ST_PAUSE: begin
                if (cmd == CMD_STOP) begin
                    state_d    = ST_IDLE;
                    step_idx_d = '0;
                    tmr_clear  = 1'b1;
                end else if (cmd == CMD_START) begin
                    state_d = ST_RUN;
                    // The resume edge counts, but never wraps, so resuming cannot fire
                    tmr_en  = ~tmr_boundary;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                step_idx_d = '0;
                tmr_clear  = 1'b1;
            end
        endcase
    end

    // Trigger pulses and status outputs; fire reads the pattern before any same-edge write
    always_comb begin
        go_d        = '0;
        step_tick_d = 1'b0;
        if (fire) begin
            go_d        = pattern_q[fire_step] & ~bus.mute;
            step_tick_d = 1'b1;
        end
        running_d = (state_d == ST_RUN);
    end

    // Pattern write port, usable in every state
    always_comb begin
        pattern_d = pattern_q;
        if (bus.pat_we) begin
            pattern_d[bus.pat_step][bus.pat_voice] = bus.pat_val;
        end
    end

    // State, output and pattern registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            step_idx_q  <= '0;
            go_q        <= '0;
            step_tick_q <= 1'b0;
            running_q   <= 1'b0;
            pattern_q   <= '{default: '0};
        end else begin
            state_q     <= state_d;
            step_idx_q  <= step_idx_d;
            go_q        <= go_d;
            step_tick_q <= step_tick_d;
            running_q   <= running_d;
            pattern_q   <= pattern_d;
        end
    end

    assign bus.go        = go_q;
    assign bus.step_idx  = step_idx_q;
    assign bus.step_tick = step_tick_q;
    assign bus.running   = running_q;

endmodule
